// File: rtl/shot_turn_controller.sv
// Turn/shot sequencer for a pool game: aim with auto-repeat charge keys, fire,
// wait for the table to settle, then score the shot and decide whose turn is next.
module shot_turn_controller #(
  parameter int NUM_BALLS          = 4,
  parameter int CHARGE_RATE_FRAMES = 4,
  parameter int SETTLE_FRAMES      = 8
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 upKey,
  input  logic                 downKey,
  input  logic                 leftKey,
  input  logic                 rightKey,
  input  logic                 enterKey,
  input  logic                 newGame,
  input  logic [NUM_BALLS-1:0] ballMoving,
  input  logic [NUM_BALLS-1:0] pocketed,
  output logic                 chargeUp,
  output logic                 chargeDown,
  output logic                 chargeLeft,
  output logic                 chargeRight,
  output logic                 releaseBall,
  output logic                 whiteRespawn,
  output logic                 foul,
  output logic                 playerTurn,
  output logic [3:0]           score0,
  output logic [3:0]           score1,
  output logic [2:0]           gameState,
  output logic                 gameOver
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_AIM     = 3'd1,
    S_FIRE    = 3'd2,
    S_ROLLING = 3'd3,
    S_SCORE   = 3'd4,
    S_OVER    = 3'd5
  } state_t;

  localparam int SW = $clog2(SETTLE_FRAMES + 1);
  localparam int RW = $clog2(CHARGE_RATE_FRAMES + 1);

  state_t                 state;
  logic [SW-1:0]          settle_cnt;
  logic [SW-1:0]          settle_next;
  logic                   settle_done;
  logic [NUM_BALLS-1:0]   pocket_mask;
  logic [NUM_BALLS-1:0]   mask_next;
  logic [NUM_BALLS-1:1]   sunk_mask;
  logic [3:0]             dir;
  logic [3:0]             dir_prev;
  logic [3:0]             dir_rise;
  logic                   enter_prev;
  logic                   enter_rise;
  logic [3:0]             armed;
  logic [RW-1:0]          rep_cnt [4];
  logic [3:0]             charge;
  int unsigned            n_pocketed;

  function automatic int unsigned popcount(input logic [NUM_BALLS-1:1] m);
    int unsigned c;
    c = 0;
    for (int i = 1; i < NUM_BALLS; i++) c += 32'(m[i]);
    return c;
  endfunction

  function automatic logic [3:0] sat_add(input logic [3:0] s, input int unsigned k);
    int unsigned t;
    t = 32'(s) + k;
    return (t > 15) ? 4'd15 : t[3:0];
  endfunction

  assign dir        = {upKey, downKey, leftKey, rightKey};
  assign dir_rise   = dir & ~dir_prev;
  assign enter_rise = enterKey & ~enter_prev;
  assign mask_next  = pocket_mask | pocketed;
  assign n_pocketed = popcount(pocket_mask[NUM_BALLS-1:1]);

  // Any moving ball restarts the settle window; only quiet frames advance it.
  always_comb begin
    settle_next = settle_cnt;
    if (|ballMoving)
      settle_next = '0;
    else if (startOfFrame)
      settle_next = settle_cnt + 1'b1;
  end
  assign settle_done = (settle_next == SW'(SETTLE_FRAMES));

  assign chargeUp    = charge[3];
  assign chargeDown  = charge[2];
  assign chargeLeft  = charge[1];
  assign chargeRight = charge[0];
  assign gameState   = state;
  assign gameOver    = (state == S_OVER);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= S_IDLE;
      settle_cnt   <= '0;
      pocket_mask  <= '0;
      sunk_mask    <= '0;
      dir_prev     <= '0;
      enter_prev   <= 1'b0;
      armed        <= '0;
      for (int i = 0; i < 4; i++) rep_cnt[i] <= '0;
      charge       <= '0;
      releaseBall  <= 1'b0;
      foul         <= 1'b0;
      whiteRespawn <= 1'b0;
      playerTurn   <= 1'b0;
      score0       <= '0;
      score1       <= '0;
    end else begin
      dir_prev     <= dir;
      enter_prev   <= enterKey;
      charge       <= '0;
      releaseBall  <= 1'b0;
      foul         <= 1'b0;
      whiteRespawn <= 1'b0;

      if (newGame) begin
        state       <= S_IDLE;
        settle_cnt  <= '0;
        pocket_mask <= '0;
        sunk_mask   <= '0;
        armed       <= '0;
        for (int i = 0; i < 4; i++) rep_cnt[i] <= '0;
        playerTurn  <= 1'b0;
        score0      <= '0;
        score1      <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            settle_cnt <= settle_done ? '0 : settle_next;
            if (settle_done) state <= S_AIM;
          end

          S_AIM: begin
            if (enter_rise) begin
              state       <= S_FIRE;
              releaseBall <= 1'b1;
              armed       <= '0;
              for (int i = 0; i < 4; i++) rep_cnt[i] <= '0;
            end else begin
              // Each direction key repeats on its own frame count from its press edge.
              for (int i = 0; i < 4; i++) begin
                if (dir_rise[i]) begin
                  charge[i]  <= 1'b1;
                  armed[i]   <= 1'b1;
                  rep_cnt[i] <= '0;
                end else if (!dir[i]) begin
                  armed[i]   <= 1'b0;
                  rep_cnt[i] <= '0;
                end else if (armed[i] && startOfFrame) begin
                  if (rep_cnt[i] == RW'(CHARGE_RATE_FRAMES - 1)) begin
                    charge[i]  <= 1'b1;
                    rep_cnt[i] <= '0;
                  end else begin
                    rep_cnt[i] <= rep_cnt[i] + 1'b1;
                  end
                end
              end
            end
          end

          S_FIRE: begin
            pocket_mask <= '0;
            settle_cnt  <= '0;
            state       <= S_ROLLING;
          end

          S_ROLLING: begin
            pocket_mask <= mask_next;
            settle_cnt  <= settle_done ? '0 : settle_next;
            // Foul is flagged on entry so it is visible during the scoring clock.
            if (settle_done) begin
              state        <= S_SCORE;
              foul         <= mask_next[0];
              whiteRespawn <= mask_next[0];
            end
          end

          S_SCORE: begin
            if (playerTurn) score1 <= sat_add(score1, n_pocketed);
            else            score0 <= sat_add(score0, n_pocketed);
            if (pocket_mask[0] || n_pocketed == 0)
              playerTurn <= ~playerTurn;
            sunk_mask <= sunk_mask | pocket_mask[NUM_BALLS-1:1];
            if (&(sunk_mask | pocket_mask[NUM_BALLS-1:1])) state <= S_OVER;
            else                                           state <= S_IDLE;
          end

          S_OVER: state <= S_OVER;

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shot_turn_controller.sv
// Directed vector bench for shot_turn_controller: a full four-shot game plus
// hand-written reset corner cases.
module tb_shot_turn_controller;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  logic       upKey, downKey, leftKey, rightKey, enterKey;
  logic       newGame;
  logic [3:0] ballMoving;
  logic [3:0] pocketed;
  logic       chargeUp, chargeDown, chargeLeft, chargeRight;
  logic       releaseBall, whiteRespawn, foul, playerTurn, gameOver;
  logic [3:0] score0, score1;
  logic [2:0] gameState;

  int checks = 0;
  int errors = 0;

  shot_turn_controller #(
    .NUM_BALLS(4), .CHARGE_RATE_FRAMES(4), .SETTLE_FRAMES(8)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .upKey(upKey), .downKey(downKey), .leftKey(leftKey), .rightKey(rightKey),
    .enterKey(enterKey), .newGame(newGame), .ballMoving(ballMoving),
    .pocketed(pocketed), .chargeUp(chargeUp), .chargeDown(chargeDown),
    .chargeLeft(chargeLeft), .chargeRight(chargeRight),
    .releaseBall(releaseBall), .whiteRespawn(whiteRespawn), .foul(foul),
    .playerTurn(playerTurn), .score0(score0), .score1(score1),
    .gameState(gameState), .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  // keys = {up, down, left, right, enter}; chg = {up, down, left, right}
  typedef struct {
    string      nm;
    logic [4:0] keys;
    logic       sof;
    logic [3:0] mov;
    logic [3:0] pk;
    logic       ng;
    logic [3:0] chg;
    logic       rel;
    logic       fl;
    logic [2:0] st;
    logic       turn;
    logic [3:0] s0;
    logic [3:0] s1;
  } vec_t;

  vec_t vq[$];

  function automatic logic [19:0] actual();
    return {chargeUp, chargeDown, chargeLeft, chargeRight, releaseBall, foul,
            whiteRespawn, gameState, gameOver, playerTurn, score0, score1};
  endfunction

  function automatic logic [19:0] expect_of(input vec_t v);
    return {v.chg, v.rel, v.fl, v.fl, v.st, (v.st == 3'd5), v.turn, v.s0, v.s1};
  endfunction

  task automatic add(input string nm, input logic [4:0] keys, input logic sof,
                     input logic [3:0] mov, input logic [3:0] pk, input logic ng,
                     input logic [3:0] chg, input logic rel, input logic fl,
                     input logic [2:0] st, input logic turn,
                     input logic [3:0] s0, input logic [3:0] s1);
    vec_t v;
    v.nm = nm; v.keys = keys; v.sof = sof; v.mov = mov; v.pk = pk; v.ng = ng;
    v.chg = chg; v.rel = rel; v.fl = fl; v.st = st; v.turn = turn;
    v.s0 = s0; v.s1 = s1;
    vq.push_back(v);
  endtask

  task automatic add_frames(input string nm, input int n, input logic [2:0] st,
                            input logic turn, input logic [3:0] s0, input logic [3:0] s1);
    for (int i = 0; i < n; i++) add(nm, 5'b0, 1'b1, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0, st, turn, s0, s1);
  endtask

  task automatic drive(input logic [4:0] keys, input logic sof, input logic [3:0] mov,
                       input logic [3:0] pk, input logic ng);
    {upKey, downKey, leftKey, rightKey, enterKey} = keys;
    startOfFrame = sof; ballMoving = mov; pocketed = pk; newGame = ng;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h", nm, act, exp);
    end
  endtask

  task automatic build_table();
    // Settle into AIM, with a moving ball restarting the count part-way.
    add_frames("idle_pre", 3, 3'd0, 1'b0, 4'd0, 4'd0);
    add("move_clr", 5'b0, 1'b1, 4'b0001, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 4'd0);
    add_frames("idle_settle", 7, 3'd0, 1'b0, 4'd0, 4'd0);
    add("aim_8th", 5'b0, 1'b1, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 3'd1, 1'b0, 4'd0, 4'd0);
    // Held up key: edge pulse then every 4th frame.
    add("up_edge", 5'b10000, 1'b0, 4'b0, 4'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 3'd1, 1'b0, 4'd0, 4'd0);
    for (int i = 1; i <= 9; i++)
      add("up_hold", 5'b10000, 1'b1, 4'b0, 4'b0, 1'b0, (i == 4 || i == 8) ? 4'b1000 : 4'b0000,
          1'b0, 1'b0, 3'd1, 1'b0, 4'd0, 4'd0);
    add("up_rel", 5'b0, 1'b0, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 3'd1, 1'b0, 4'd0, 4'd0);
    add("opposing", 5'b11000, 1'b0, 4'b0, 4'b0, 1'b0, 4'b1100, 1'b0, 1'b0, 3'd1, 1'b0, 4'd0, 4'd0);
    add("opp_rel", 5'b0, 1'b0, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 3'd1, 1'b0, 4'd0, 4'd0);
    // Release must clear the repeat counter.
    add("rep_p1", 5'b10000, 1'b0, 4'b0, 4'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 3'd1, 1'b0, 4'd0, 4'd0);
    add("rep_h1", 5'b10000, 1'b1, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 3'd1, 1'b0, 4'd0, 4'd0);
    add("rep_h1", 5'b10000, 1'b1, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 3'd1, 1'b0, 4'd0, 4'd0);
    add("rep_rel", 5'b0, 1'b0, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 3'd1, 1'b0, 4'd0, 4'd0);
    add("rep_p2", 5'b10000, 1'b0, 4'b0, 4'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 3'd1, 1'b0, 4'd0, 4'd0);
    for (int i = 1; i <= 4; i++)
      add("rep_h2", 5'b10000, 1'b1, 4'b0, 4'b0, 1'b0, (i == 4) ? 4'b1000 : 4'b0000,
          1'b0, 1'b0, 3'd1, 1'b0, 4'd0, 4'd0);
    add("rep_rel2", 5'b0, 1'b0, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 3'd1, 1'b0, 4'd0, 4'd0);
    // Shot 1, player 0: enter+left together, pockets balls 2 and 3.
    add("fire_left", 5'b00101, 1'b0, 4'b0, 4'b0, 1'b0, 4'b0, 1'b1, 1'b0, 3'd2, 1'b0, 4'd0, 4'd0);
    add("rolling", 5'b00101, 1'b0, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 3'd3, 1'b0, 4'd0, 4'd0);
    add("keys_off", 5'b0, 1'b0, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 3'd3, 1'b0, 4'd0, 4'd0);
    add("pk2", 5'b0, 1'b0, 4'b1111, 4'b0100, 1'b0, 4'b0, 1'b0, 1'b0, 3'd3, 1'b0, 4'd0, 4'd0);
    add("pk3", 5'b0, 1'b1, 4'b1111, 4'b1000, 1'b0, 4'b0, 1'b0, 1'b0, 3'd3, 1'b0, 4'd0, 4'd0);
    add_frames("s1_settle", 7, 3'd3, 1'b0, 4'd0, 4'd0);
    add("s1_score", 5'b0, 1'b1, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 3'd4, 1'b0, 4'd0, 4'd0);
    add("s1_done", 5'b0, 1'b0, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd2, 4'd0);
    // Shot 2, player 0: white pocketed on the settle clock, ball 1 during SCORE ignored.
    add_frames("s2_idle", 7, 3'd0, 1'b0, 4'd2, 4'd0);
    add("s2_aim", 5'b0, 1'b1, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 3'd1, 1'b0, 4'd2, 4'd0);
    add("s2_fire", 5'b00001, 1'b0, 4'b0, 4'b0, 1'b0, 4'b0, 1'b1, 1'b0, 3'd2, 1'b0, 4'd2, 4'd0);
    add("s2_roll", 5'b0, 1'b0, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 3'd3, 1'b0, 4'd2, 4'd0);
    add_frames("s2_settle", 7, 3'd3, 1'b0, 4'd2, 4'd0);
    add("s2_white", 5'b0, 1'b1, 4'b0, 4'b0001, 1'b0, 4'b0, 1'b0, 1'b1, 3'd4, 1'b0, 4'd2, 4'd0);
    add("s2_pk_score", 5'b0, 1'b0, 4'b0, 4'b0010, 1'b0, 4'b0, 1'b0, 1'b0, 3'd0, 1'b1, 4'd2, 4'd0);
    // Shot 3, player 1: zero-power shot, nothing pocketed -> turn passes.
    add_frames("s3_idle", 7, 3'd0, 1'b1, 4'd2, 4'd0);
    add("s3_aim", 5'b0, 1'b1, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 3'd1, 1'b1, 4'd2, 4'd0);
    add("s3_fire", 5'b00001, 1'b0, 4'b0, 4'b0, 1'b0, 4'b0, 1'b1, 1'b0, 3'd2, 1'b1, 4'd2, 4'd0);
    add("s3_roll", 5'b0, 1'b0, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 3'd3, 1'b1, 4'd2, 4'd0);
    add_frames("s3_settle", 7, 3'd3, 1'b1, 4'd2, 4'd0);
    add("s3_score", 5'b0, 1'b1, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 3'd4, 1'b1, 4'd2, 4'd0);
    add("s3_done", 5'b0, 1'b0, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd2, 4'd0);
    // Shot 4, player 0: last object ball -> game over.
    add_frames("s4_idle", 7, 3'd0, 1'b0, 4'd2, 4'd0);
    add("s4_aim", 5'b0, 1'b1, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 3'd1, 1'b0, 4'd2, 4'd0);
    add("s4_fire", 5'b00001, 1'b0, 4'b0, 4'b0, 1'b0, 4'b0, 1'b1, 1'b0, 3'd2, 1'b0, 4'd2, 4'd0);
    add("s4_roll", 5'b0, 1'b0, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 3'd3, 1'b0, 4'd2, 4'd0);
    add("s4_pk1", 5'b0, 1'b0, 4'b0, 4'b0010, 1'b0, 4'b0, 1'b0, 1'b0, 3'd3, 1'b0, 4'd2, 4'd0);
    add_frames("s4_settle", 7, 3'd3, 1'b0, 4'd2, 4'd0);
    add("s4_score", 5'b0, 1'b1, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 3'd4, 1'b0, 4'd2, 4'd0);
    add("s4_over", 5'b0, 1'b0, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 3'd5, 1'b0, 4'd3, 4'd0);
    add_frames("over_hold", 9, 3'd5, 1'b0, 4'd3, 4'd0);
    add("over_key", 5'b10000, 1'b0, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 3'd5, 1'b0, 4'd3, 4'd0);
    add("new_game", 5'b0, 1'b0, 4'b0, 4'b0, 1'b1, 4'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 4'd0);
    // newGame wins over enter in AIM.
    add_frames("ng_idle", 7, 3'd0, 1'b0, 4'd0, 4'd0);
    add("ng_aim", 5'b0, 1'b1, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 3'd1, 1'b0, 4'd0, 4'd0);
    add("ng_prio", 5'b00001, 1'b0, 4'b0, 4'b0, 1'b1, 4'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 4'd0);
    add("ng_off", 5'b0, 1'b0, 4'b0, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 4'd0);
  endtask

  initial begin
    resetN = 1'b0;
    drive(5'b0, 1'b0, 4'b0, 4'b0, 1'b0);
    build_table();

    // Reset state: every output zero, IDLE.
    tick();
    tick();
    chk("reset_state", actual(), 20'h0);
    resetN = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].keys, vq[i].sof, vq[i].mov, vq[i].pk, vq[i].ng);
      tick();
      chk(vq[i].nm, actual(), expect_of(vq[i]));
    end

    // Mid-shot reset with keys still held: restart in IDLE, no pulses from old history.
    drive(5'b0, 1'b1, 4'b0, 4'b0, 1'b0);
    repeat (8) tick();
    chk("mr_aim", {29'b0, gameState}, 32'd1);
    drive(5'b10001, 1'b0, 4'b0, 4'b0, 1'b0);
    tick();
    chk("mr_fire", actual(), {4'b0, 1'b1, 2'b0, 3'd2, 1'b0, 1'b0, 8'h0});
    resetN = 1'b0;
    #1;
    chk("mr_async", actual(), 20'h0);
    tick();
    tick();
    chk("mr_held", actual(), 20'h0);
    resetN = 1'b1;
    tick();
    chk("mr_release", actual(), 20'h0);
    drive(5'b10001, 1'b1, 4'b0, 4'b0, 1'b0);
    repeat (8) tick();
    chk("mr_aim2", actual(), {4'b0, 3'b0, 3'd1, 1'b0, 1'b0, 8'h0});
    repeat (4) tick();
    chk("mr_no_edge", actual(), {4'b0, 3'b0, 3'd1, 1'b0, 1'b0, 8'h0});
    drive(5'b00000, 1'b0, 4'b0, 4'b0, 1'b0);
    tick();
    drive(5'b10000, 1'b0, 4'b0, 4'b0, 1'b0);
    tick();
    chk("mr_fresh_edge", actual(), {4'b1000, 3'b0, 3'd1, 1'b0, 1'b0, 8'h0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
